muldiv_ctrl: RTL

Sequencer for the multicycle multiply and divide units in the CPU datapath. It accepts HI/LO-class operations from the main control unit: MULT, DIV, MFHI, MFLO, MTHI and MTLO. It launches the selected unit, times its run with an internal latency counter, and captures the result into the architectural HI/LO registers. While a unit is running it stalls the pipeline control through `op_ready`/`busy`.

---
 rtl/muldiv_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for the multicycle multiply and divide units: launches a unit, times it, captures HI/LO.
// Optional divide-by-zero trap enabled by defining MULDIV_DIV0_CHECK_EN.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 33,
    parameter int DIV_CYCLES = 34
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    output logic        busy,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mul_start,
    output logic        div_start,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        div_zero
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MFHI = 3'b011;
    localparam logic [2:0] OP_MFLO = 3'b100;
    localparam logic [2:0] OP_MTHI = 3'b101;
    localparam logic [2:0] OP_MTLO = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               is_div_reg;

`ifndef MULDIV_DIV0_CHECK_EN
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            op_ready   <= 1'b1;
            busy       <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
            mul_start  <= 1'b0;
            div_start  <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
`ifdef MULDIV_DIV0_CHECK_EN
            div_zero   <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
`ifdef MULDIV_DIV0_CHECK_EN
            div_zero <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT: begin
                                unit_a     <= rs_val;
                                unit_b     <= rt_val;
                                is_div_reg <= 1'b0;
                                mul_start  <= 1'b1;
                                op_ready   <= 1'b0;
                                busy       <= 1'b1;
                                state_reg  <= ST_ISSUE;
                            end
                            OP_DIV: begin
`ifdef MULDIV_DIV0_CHECK_EN
                                // Trapped divide: the divider is never launched.
                                if (rt_val == 32'd0) div_zero <= 1'b1;
                                else
`endif
                                begin
                                    unit_a     <= rs_val;
                                    unit_b     <= rt_val;
                                    is_div_reg <= 1'b1;
                                    div_start  <= 1'b1;
                                    op_ready   <= 1'b0;
                                    busy       <= 1'b1;
                                    state_reg  <= ST_ISSUE;
                                end
                            end
                            OP_MFHI: begin
                                rd_data  <= hi;
                                rd_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data  <= lo;
                                rd_valid <= 1'b1;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    mul_start <= 1'b0;
                    div_start <= 1'b0;
                    cnt_reg   <= is_div_reg ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) state_reg <= ST_WRITE;
                end
                ST_WRITE: begin
                    // The only edge on which unit results are sampled.
                    if (is_div_reg) begin
                        hi <= div_hi;
                        lo <= div_lo;
                    end else begin
                        hi <= mul_hi;
                        lo <= mul_lo;
                    end
                    op_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
